// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM stage: memory op codes, FSM states and op-class helpers.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LBU  = 4'd2,
    MEMOP_LH   = 4'd3,
    MEMOP_LHU  = 4'd4,
    MEMOP_LW   = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8
  } memop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store byte enables/replicated data, load lane select and extension,
// and the misalignment check for the current op.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  memop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [7:0]  lane_b_s;
  logic [15:0] lane_h_s;

  // Lane selection and per-op steering/extension
  always_comb begin
    lane_b_s   = rdata[{addr_lo, 3'b000} +: 8];
    lane_h_s   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be         = 4'b0000;
    wdata      = sdata;
    ld_data    = rdata;
    misaligned = 1'b0;
    case (memop)
      MEMOP_LB:  ld_data = {{24{lane_b_s[7]}}, lane_b_s};
      MEMOP_LBU: ld_data = {24'd0, lane_b_s};
      MEMOP_LH: begin
        ld_data    = {{16{lane_h_s[15]}}, lane_h_s};
        misaligned = addr_lo[0];
      end
      MEMOP_LHU: begin
        ld_data    = {16'd0, lane_h_s};
        misaligned = addr_lo[0];
      end
      MEMOP_LW:  misaligned = (addr_lo != 2'b00);
      MEMOP_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{sdata[7:0]}};
      end
      MEMOP_SH: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{sdata[15:0]}};
        misaligned = addr_lo[0];
      end
      MEMOP_SW: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM pipeline stage: passes non-memory results through, runs loads/stores on a req/ack bus
// while stalling the pipeline, with a saturating timeout that aborts hung transfers.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wreg,
  input  logic [3:0]  mem_memop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic [4:0]  wb_wd,
  output logic [31:0] wb_wdata,
  output logic        wb_wreg,
  output logic        stall_req,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        ld_op_s, st_op_s, mem_op_s, mis_s;
  logic [3:0]  align_be_s;
  logic [31:0] align_wdata_s, ld_data_s;

  assign ld_op_s  = is_load(mem_memop);
  assign st_op_s  = is_store(mem_memop);
  assign mem_op_s = ld_op_s || st_op_s;

  // Load extension reads the captured bus word, so DONE sees stable data.
  mem_lsu_align u_align (
    .memop      (mem_memop),
    .addr_lo    (mem_addr[1:0]),
    .sdata      (mem_sdata),
    .rdata      (buf_q),
    .be         (align_be_s),
    .wdata      (align_wdata_s),
    .ld_data    (ld_data_s),
    .misaligned (mis_s)
  );

  // Transfer FSM, timeout counter, load buffer and bus request registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s && !mis_s) begin
          state_d = ST_BUSY;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          we_d    = st_op_s;
          be_d    = align_be_s;
          addr_d  = {mem_addr[31:2], 2'b00};
          wdata_d = align_wdata_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dbus_ack) begin
          buf_d   = dbus_rdata;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      buf_q   <= 32'd0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Writeback, stall and exception outputs; forced low while in reset
  always_comb begin
    wb_wd     = 5'd0;
    wb_wdata  = 32'd0;
    wb_wreg   = 1'b0;
    stall_req = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    if (!rst) begin
      wb_wd    = mem_wd;
      wb_wdata = ld_op_s ? ld_data_s : mem_wdata;
      if (ld_op_s) begin
        wb_wreg = mem_wreg && !mis_s && (state_q == ST_DONE) && !err_q;
      end else if (st_op_s) begin
        wb_wreg = 1'b0;
      end else begin
        wb_wreg = mem_wreg;
      end
      stall_req = mem_op_s && !mis_s && (state_q != ST_DONE);
      exc_adel  = ld_op_s && mis_s;
      exc_ades  = st_op_s && mis_s;
    end else begin
      wb_wd = 5'd0;
    end
  end

  assign bus_err    = err_q;
  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_be    = be_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a driver acts as pipeline and bus slave and queues expected
// writebacks/bus transfers from a lane-arithmetic model; a monitor pops and compares.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TO = 4;

  logic        clk, rst;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_addr, mem_sdata;
  logic        mem_wreg;
  logic [3:0]  mem_memop;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        wb_wreg, stall_req, exc_adel, exc_ades, bus_err;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;

  mem_lsu #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg), .mem_memop(mem_memop),
    .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .wb_wd(wb_wd), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg), .stall_req(stall_req),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        chk_data;
    logic        wreg, adel, ades, berr;
    int          stalls;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    int          cycles;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one instruction: model the expected result, then act as pipeline + bus slave.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] alu, input logic [4:0] wd, input logic wreg,
                       input int delay, input logic [31:0] rdata, input int abort_at);
    exp_t e;
    bus_t b;
    int size, off, busy;
    logic ld, st, sgn, mis, adv;
    longint unsigned m, v;
    ld   = (op >= 4'd1) && (op <= 4'd5);
    st   = (op >= 4'd6) && (op <= 4'd8);
    sgn  = (op == MEMOP_LB) || (op == MEMOP_LH);
    size = (op == MEMOP_LB || op == MEMOP_LBU || op == MEMOP_SB) ? 1 :
           (op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_SH) ? 2 :
           (op == MEMOP_LW || op == MEMOP_SW) ? 4 : 0;
    off  = int'(addr % 32'd4);
    mis  = (size != 0) && ((addr % size) != 0);
    e.wd = wd; e.adel = ld && mis; e.ades = st && mis;
    e.wdata = alu; e.chk_data = 1'b0; e.wreg = 1'b0; e.berr = 1'b0; e.stalls = 0;
    if (size == 0) begin
      e.chk_data = 1'b1;
      e.wreg = wreg;
    end else if (!mis) begin
      e.berr   = (delay >= TO);
      busy     = e.berr ? TO : delay + 1;
      e.stalls = 1 + busy;
      if (ld) begin
        m = (64'd1 << (8 * size)) - 64'd1;
        v = (64'(rdata) >> (8 * off)) & m;
        if (sgn && v[8 * size - 1]) v = v | ~m;
        e.wdata = v[31:0];
        e.chk_data = !e.berr;
        e.wreg = wreg && !e.berr;
      end
      b.we = st;
      b.be = 4'(((1 << size) - 1) << off);
      b.addr = addr & 32'hFFFF_FFFC;
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = sdata[8*(i % size) +: 8];
      b.cycles = busy;
      bus_q.push_back(b);
    end
    if (abort_at == 0) exp_q.push_back(e);

    mem_memop = op; mem_addr = addr; mem_sdata = sdata;
    mem_wdata = alu; mem_wd = wd; mem_wreg = wreg;
    busy = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (dbus_req) begin
        busy++;
        dbus_ack = (busy - 1 == delay);
        dbus_rdata = dbus_ack ? rdata : $urandom;
      end else begin
        dbus_ack = ($urandom_range(0, 3) == 0);
        dbus_rdata = $urandom;
      end
      if (abort_at > 0 && busy == abort_at) begin
        rst = 1'b1;
        dbus_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem_memop = MEMOP_NONE;
        return;
      end
      adv = !stall_req;
      @(negedge clk);
      if (adv) begin
        dbus_ack = 1'b0;
        return;
      end
    end
  endtask

  // Monitor: reset checks, bus transfer checks and writeback scoreboard compare.
  initial begin
    int stall_cnt, req_cnt;
    logic in_req, rst_prev;
    exp_t e;
    bus_t b;
    stall_cnt = 0; req_cnt = 0; in_req = 1'b0; rst_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (done) begin
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      if (rst) begin
        chk("rst_comb", {wb_wd, wb_wdata, wb_wreg, stall_req, exc_adel, exc_ades}, 64'd0);
        if (rst_prev) begin
          chk("rst_regs", {dbus_req, bus_err, dbus_we, dbus_be}, 64'd0);
          chk("rst_addr", 64'(dbus_addr), 64'd0);
        end
        stall_cnt = 0;
        if (in_req && bus_q.size() > 0) void'(bus_q.pop_front());
        in_req = 1'b0;
      end else begin
        if (dbus_req) begin
          if (!in_req) begin
            req_cnt = 0;
            if (bus_q.size() == 0) begin
              chk("bus_unexpected", 64'd1, 64'd0);
            end else begin
              b = bus_q[0];
              chk("bus_we", 64'(dbus_we), 64'(b.we));
              chk("bus_addr", 64'(dbus_addr), 64'(b.addr));
              if (b.we) begin
                chk("bus_be", 64'(dbus_be), 64'(b.be));
                chk("bus_wdata", 64'(dbus_wdata), 64'(b.wdata));
              end
            end
          end
          req_cnt++;
          in_req = 1'b1;
        end else if (in_req) begin
          if (bus_q.size() > 0) begin
            b = bus_q.pop_front();
            chk("bus_req_cycles", 64'(req_cnt), 64'(b.cycles));
          end
          in_req = 1'b0;
        end
        if (stall_req) begin
          stall_cnt++;
          chk("stall_wreg_bus_err", {wb_wreg, bus_err}, 64'd0);
          if (stall_cnt == 40) chk("stall_bound", 64'd1, 64'd0);
        end else if (exp_q.size() == 0) begin
          chk("wb_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", 64'(stall_cnt), 64'(e.stalls));
          chk("wb_wd", 64'(wb_wd), 64'(e.wd));
          chk("wb_wreg", 64'(wb_wreg), 64'(e.wreg));
          chk("exc_flags", {exc_adel, exc_ades}, {e.adel, e.ades});
          chk("bus_err", 64'(bus_err), 64'(e.berr));
          if (e.chk_data) chk("wb_wdata", 64'(wb_wdata), 64'(e.wdata));
          stall_cnt = 0;
        end
      end
      rst_prev = rst;
    end
  end

  // Stimulus: reset, directed corner cases, then randomized traffic.
  initial begin
    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'd0;
    mem_memop = MEMOP_NONE; mem_addr = 32'd0; mem_sdata = 32'd0;
    mem_wdata = 32'd0; mem_wd = 5'd0; mem_wreg = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(MEMOP_LB,   32'h103, 32'd0, 32'h1111, 5'd3, 1'b1, 0, 32'h80FF_1234, 0);
    issue(MEMOP_LHU,  32'h202, 32'd0, 32'h2222, 5'd4, 1'b1, 1, 32'hBEEF_0000, 0);
    issue(MEMOP_LH,   32'h202, 32'd0, 32'h3333, 5'd5, 1'b1, 2, 32'hBEEF_0000, 0);
    issue(MEMOP_SB,   32'h11,  32'h0000_00A5, 32'h4444, 5'd6, 1'b1, 0, 32'h0, 0);
    issue(MEMOP_LW,   32'h6,   32'd0, 32'h5555, 5'd7, 1'b1, 0, 32'h0, 0);
    issue(MEMOP_NONE, 32'h8,   32'd0, 32'hCAFE_F00D, 5'd8, 1'b1, 0, 32'h0, 0);
    issue(MEMOP_LW,   32'h40,  32'd0, 32'h6666, 5'd9, 1'b1, 10, 32'h1234_5678, 0);
    issue(MEMOP_SH,   32'h22,  32'h0000_BEEF, 32'h7777, 5'd10, 1'b1, 3, 32'h0, 0);
    issue(MEMOP_LW,   32'h80,  32'd0, 32'h8888, 5'd11, 1'b1, 10, 32'h0, 2);
    issue(MEMOP_LW,   32'h84,  32'd0, 32'h9999, 5'd12, 1'b1, 0, 32'hDEAD_BEEF, 0);
    for (int i = 0; i < 200; i++) begin
      issue(4'($urandom_range(0, 9)), $urandom, $urandom, $urandom, 5'($urandom),
            1'($urandom), $urandom_range(0, 5), $urandom, 0);
    end
    done = 1'b1;
  end

endmodule
